// File: rtl/dither_pkg.sv
// Shared definitions for the dither scheduler, inhibit gate and lock modules.
// Holds the sequencer state encoding and the channel-index width helper.
package dither_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SEL   = 3'd1,
        S_ARM   = 3'd2,
        S_DWELL = 3'd3,
        S_GAP   = 3'd4,
        S_FIN   = 3'd5
    } state_t;

    // Width of a channel index; a single channel still needs one bit.
    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int NCH_DEF = 3;
    localparam int CHW     = ch_width(NCH_DEF);

endpackage

// File: rtl/dither_edge_cnt.sv
// Rising-edge detector on one trigger line feeding a saturating event counter.
// The counter holds at zero while clr is high.
module dither_edge_cnt
    import dither_pkg::*;
#(
    parameter int NDW = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           clr,
    input  logic           trig,
    output logic [NDW-1:0] cnt
);

    logic trig_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trig_q <= 1'b0;
        end else begin
            trig_q <= trig;
        end
    end

    // Saturate at all-ones so a runaway trigger can never wrap back below the dwell target.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (trig && !trig_q && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/dither_share_scheduler.sv
// Sequences the dither-inhibit gate enables so one error detector is time-shared
// between NCH dither locks: at most one channel is dithered at a time.
module dither_share_scheduler
    import dither_pkg::*;
#(
    parameter int NCH     = 3,
    parameter int NDW     = 16,
    parameter int TO_CLKS = 100000,
    parameter int NGAP    = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           abort,
    input  logic [NCH-1:0] ch_mask,
    input  logic [NDW-1:0] dwell_cyc,
    input  logic [NCH-1:0] inhtrig,
    input  logic [NCH-1:0] inthld,
    output logic [NCH-1:0] en,
    output logic           busy,
    output logic           done,
    output logic           fault,
    output logic [2:0]     fault_ch,
    output state_t         state
);

    localparam int CW = ch_width(NCH);
    localparam int GW = (NGAP > 1) ? $clog2(NGAP) : 1;

    // Handshake: start is a one-clk request taken only when busy is low;
    // done is a one-clk completion pulse, withheld on abort or fault.

    state_t          state_n;
    logic [CW-1:0]   ch, ch_n;
    logic [NCH-1:0]  mask_r, mask_n;
    logic [NDW-1:0]  dw_r, dw_n;
    logic [31:0]     toc, toc_n;
    logic [GW-1:0]   gap, gap_n;
    logic [NCH-1:0]  en_n;
    logic            done_n;
    logic            fault_n;
    logic [2:0]      fault_ch_n;
    logic [NDW-1:0]  dc;

    // One counter serves every channel; ch only changes outside DWELL, where it is held clear.
    dither_edge_cnt #(
        .NDW (NDW)
    ) u_edge_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (state != S_DWELL),
        .trig (inhtrig[ch]),
        .cnt  (dc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            ch       <= '0;
            mask_r   <= '0;
            dw_r     <= '0;
            toc      <= '0;
            gap      <= '0;
            en       <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            fault    <= 1'b0;
            fault_ch <= 3'd0;
        end else begin
            state    <= state_n;
            ch       <= ch_n;
            mask_r   <= mask_n;
            dw_r     <= dw_n;
            toc      <= toc_n;
            gap      <= gap_n;
            en       <= en_n;
            busy     <= (state_n != S_IDLE);
            done     <= done_n;
            fault    <= fault_n;
            fault_ch <= fault_ch_n;
        end
    end

    always_comb begin
        state_n    = state;
        ch_n       = ch;
        mask_n     = mask_r;
        dw_n       = dw_r;
        toc_n      = toc;
        gap_n      = gap;
        en_n       = en;
        fault_n    = fault;
        fault_ch_n = fault_ch;
        done_n     = 1'b0;

        if (abort) begin
            state_n = S_IDLE;
            en_n    = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        mask_n  = ch_mask;
                        dw_n    = dwell_cyc;
                        fault_n = 1'b0;
                        ch_n    = '0;
                        state_n = S_SEL;
                    end
                end
                // Scan one index per clk so the mux path stays a single bit select.
                S_SEL: begin
                    if (mask_r[ch]) begin
                        en_n    = NCH'(1) << ch;
                        toc_n   = '0;
                        state_n = S_ARM;
                    end else if (ch == CW'(NCH - 1)) begin
                        state_n = S_FIN;
                    end else begin
                        ch_n = ch + 1'b1;
                    end
                end
                S_ARM: begin
                    if (!inthld[ch]) begin
                        state_n = S_DWELL;
                    end else if (toc == 32'(TO_CLKS - 1)) begin
                        en_n       = '0;
                        fault_n    = 1'b1;
                        fault_ch_n = 3'(ch);
                        state_n    = S_IDLE;
                    end else begin
                        toc_n = toc + 32'd1;
                    end
                end
                S_DWELL: begin
                    if (dc == dw_r) begin
                        en_n    = '0;
                        gap_n   = '0;
                        state_n = S_GAP;
                    end
                end
                S_GAP: begin
                    if (gap == GW'(NGAP - 1)) begin
                        if (ch == CW'(NCH - 1)) begin
                            state_n = S_FIN;
                        end else begin
                            ch_n    = ch + 1'b1;
                            state_n = S_SEL;
                        end
                    end else begin
                        gap_n = gap + 1'b1;
                    end
                end
                S_FIN: begin
                    state_n = S_IDLE;
                end
                default: begin
                    state_n = S_IDLE;
                    en_n    = '0;
                end
            endcase
        end

        // done is high exactly while the FSM sits in FIN.
        done_n = (state_n == S_FIN);
    end

endmodule
